// File: rtl/ex_mem_stage_pkg.sv
// Shared constants for the EX/MEM boundary: opcode/funct encodings, ALU flag bit
// positions, the default exception vector and the stage FSM state type.
// The ALU uses the same constants so that flag positions and op codes stay in agreement.
package ex_mem_stage_pkg;

  localparam logic [5:0] OP_RTYPE    = 6'h00;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ITYPE_LO = 6'h08;
  localparam logic [5:0] OP_ITYPE_HI = 6'h0E;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SW       = 6'h2B;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;

  // alu_flags = {zero, negative, overflow}
  localparam int unsigned FLAG_ZERO = 2;
  localparam int unsigned FLAG_NEG  = 1;
  localparam int unsigned FLAG_OVF  = 0;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0080;

  typedef enum logic {StEmpty, StFull} state_e;

  // pc + 4 + (sign-extended imm16 << 2), wrapping at 32 bits
  function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [15:0] imm);
    return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ex_mem_decode.sv
// Combinational decode of the EX-stage instruction word into the control bits the
// MEM stage and the redirect logic need.
module ex_mem_decode
  import ex_mem_stage_pkg::*;
(
  input  logic [31:0] instruction,
  output logic [4:0]  dest,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        is_beq,
  output logic        is_bne,
  output logic        is_ovf_op
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       writes;
  logic       unused_fields;

  assign opcode        = instruction[31:26];
  assign funct         = instruction[5:0];
  assign unused_fields = ^{instruction[25:21], instruction[10:6]};

  // Decode opcode/funct into destination and control bits.
  always_comb begin
    dest      = 5'd0;
    writes    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_ovf_op = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dest      = instruction[15:11];
        writes    = 1'b1;
        is_ovf_op = (funct == FUNCT_ADD) || (funct == FUNCT_SUB);
      end
      OP_LW: begin
        dest     = instruction[20:16];
        writes   = 1'b1;
        mem_read = 1'b1;
      end
      OP_SW:   mem_write = 1'b1;
      OP_BEQ:  is_beq = 1'b1;
      OP_BNE:  is_bne = 1'b1;
      default: begin
        if (opcode >= OP_ITYPE_LO && opcode <= OP_ITYPE_HI) begin
          dest      = instruction[20:16];
          writes    = 1'b1;
          is_ovf_op = (opcode == OP_ADDI);
        end
      end
    endcase
    // Writes to r0 are discarded.
    reg_write = writes && (dest != 5'd0);
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM single-entry pipeline register with branch resolution.
// Optional feature: define EX_MEM_OVF_TRAP_EN to trap on signed overflow of
// add/sub/addi (suppress write-back, pulse exc_valid, redirect to EXC_VECTOR).
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instruction,
  input  logic [31:0] pc,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [2:0]  alu_flags,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [31:0] out_store_data,
  output logic [4:0]  out_dest,
  output logic        out_reg_write,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        exc_valid,
  output logic [31:0] epc
);

  state_e state_q, state_d;

  logic [4:0] dec_dest;
  logic       dec_reg_write, dec_mem_read, dec_mem_write;
  logic       dec_is_beq, dec_is_bne, dec_is_ovf_op;
  logic       capture;
  logic       branch_taken;
  logic       trap;
  logic       redirect_d;
  logic [31:0] target_d;
  logic       unused_flags;

  ex_mem_decode u_decode (
    .instruction (instruction),
    .dest        (dec_dest),
    .reg_write   (dec_reg_write),
    .mem_read    (dec_mem_read),
    .mem_write   (dec_mem_write),
    .is_beq      (dec_is_beq),
    .is_bne      (dec_is_bne),
    .is_ovf_op   (dec_is_ovf_op)
  );

  assign out_valid = (state_q == StFull);
  assign in_ready  = !out_valid || out_ready;
  // A flush kills any incoming transfer as well as the held entry.
  assign capture   = in_valid && in_ready && !flush;

  assign branch_taken = (dec_is_beq && alu_flags[FLAG_ZERO]) ||
                        (dec_is_bne && !alu_flags[FLAG_ZERO]);

`ifdef EX_MEM_OVF_TRAP_EN
  assign trap         = dec_is_ovf_op && alu_flags[FLAG_OVF];
  assign unused_flags = alu_flags[FLAG_NEG];
`else
  assign trap         = 1'b0;
  assign unused_flags = ^{alu_flags[FLAG_NEG], alu_flags[FLAG_OVF], dec_is_ovf_op};
`endif

  // Exception outranks a taken branch.
  assign redirect_d = trap || branch_taken;
  assign target_d   = trap ? EXC_VECTOR : branch_target(pc, instruction[15:0]);

  // Next-state: flush wins, then capture, then drain.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StEmpty;
    end else if (capture) begin
      state_d = StFull;
    end else if (out_ready) begin
      state_d = StEmpty;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload registers load only on capture so they hold steady through a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result     <= '0;
      out_store_data <= '0;
      out_dest       <= '0;
      out_reg_write  <= 1'b0;
      out_mem_read   <= 1'b0;
      out_mem_write  <= 1'b0;
      redirect_pc    <= '0;
    end else if (capture) begin
      out_result     <= alu_result;
      out_store_data <= store_data;
      out_dest       <= dec_dest;
      out_reg_write  <= dec_reg_write && !trap;
      out_mem_read   <= dec_mem_read;
      out_mem_write  <= dec_mem_write;
      if (redirect_d) begin
        redirect_pc <= target_d;
      end
    end
  end

  // Redirect pulse: high only in the cycle following a capturing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
    end else begin
      redirect_valid <= capture && redirect_d;
    end
  end

`ifdef EX_MEM_OVF_TRAP_EN
  // Exception pulse and faulting PC, aligned with the redirect pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_valid <= 1'b0;
      epc       <= '0;
    end else begin
      exc_valid <= capture && trap;
      if (capture && trap) begin
        epc <= pc;
      end
    end
  end
`else
  assign exc_valid = 1'b0;
  assign epc       = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: behavioural model of the stage checked every cycle,
// plus directed literal expectations. Follows EX_MEM_OVF_TRAP_EN if defined.
module tb_ex_mem_stage;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [31:0] instruction, pc, alu_result, store_data;
  logic [2:0]  alu_flags;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_result, out_store_data;
  logic [4:0]  out_dest;
  logic        out_reg_write, out_mem_read, out_mem_write;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exc_valid;
  logic [31:0] epc;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  ex_mem_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .instruction    (instruction),
    .pc             (pc),
    .alu_result     (alu_result),
    .store_data     (store_data),
    .alu_flags      (alu_flags),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_store_data (out_store_data),
    .out_dest       (out_dest),
    .out_reg_write  (out_reg_write),
    .out_mem_read   (out_mem_read),
    .out_mem_write  (out_mem_write),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exc_valid      (exc_valid),
    .epc            (epc)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] sd;
    logic [4:0]  dest;
    logic        writer;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        redir;
    logic [31:0] rpc;
    logic        exc;
    logic [31:0] epc;
  } ent_t;

  // What the stage must present for one instruction, straight from the ISA rules.
  function automatic ent_t predict(input logic [31:0] i, input logic [31:0] p,
                                   input logic [31:0] r, input logic [31:0] s,
                                   input logic [2:0] f);
    ent_t e;
    int unsigned op, fn;
    logic ovf_op, taken, trap_on;
    logic [31:0] off;
    op = i[31:26];
    fn = i[5:0];
    e = '0;
    e.result = r;
    e.sd = s;
    if (op == 0) begin
      e.writer = 1; e.dest = i[15:11];
    end else if (op >= 8 && op <= 14) begin
      e.writer = 1; e.dest = i[20:16];
    end else if (op == 'h23) begin
      e.writer = 1; e.dest = i[20:16]; e.mr = 1;
    end else if (op == 'h2B) begin
      e.mw = 1;
    end
    ovf_op = (op == 0 && (fn == 'h20 || fn == 'h22)) || op == 8;
    taken  = (op == 4 && f[2]) || (op == 5 && !f[2]);
`ifdef EX_MEM_OVF_TRAP_EN
    trap_on = 1;
`else
    trap_on = 0;
`endif
    e.exc   = trap_on && ovf_op && f[0];
    e.rw    = e.writer && e.dest != 0 && !e.exc;
    e.redir = e.exc || taken;
    off     = {{16{i[15]}}, i[15:0]};
    e.rpc   = e.exc ? 32'h80 : p + 32'd4 + off * 4;
    e.epc   = p;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: one slot that is either empty or holds a predicted entry.
  logic m_valid, m_pulse;
  ent_t m_ent;
  always @(posedge clk or negedge rst_n) begin
    ent_t e;
    if (!rst_n) begin
      m_valid <= 0;
      m_pulse <= 0;
    end else if (flush) begin
      m_valid <= 0;
      m_pulse <= 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      e = predict(instruction, pc, alu_result, store_data, alu_flags);
      m_valid <= 1;
      m_ent   <= e;
      m_pulse <= e.redir;
    end else begin
      m_pulse <= 0;
      if (out_ready) m_valid <= 0;
    end
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("m_out_valid", out_valid, m_valid);
      chk("m_in_ready", in_ready, !m_valid || out_ready);
      chk("m_redirect_valid", redirect_valid, m_pulse);
      chk("m_exc_valid", exc_valid, m_pulse && m_ent.exc);
      if (m_valid) begin
        chk("m_out_result", out_result, m_ent.result);
        chk("m_out_store_data", out_store_data, m_ent.sd);
        chk("m_out_reg_write", out_reg_write, m_ent.rw);
        chk("m_out_mem_read", out_mem_read, m_ent.mr);
        chk("m_out_mem_write", out_mem_write, m_ent.mw);
        if (m_ent.writer) chk("m_out_dest", out_dest, m_ent.dest);
      end
      if (m_pulse) chk("m_redirect_pc", redirect_pc, m_ent.rpc);
      if (m_pulse && m_ent.exc) chk("m_epc", epc, m_ent.epc);
    end
  end

  task automatic chk_zero(input string name);
    chk({name, "_out_valid"}, out_valid, 0);
    chk({name, "_redirect_valid"}, redirect_valid, 0);
    chk({name, "_exc_valid"}, exc_valid, 0);
    chk({name, "_reg_write"}, out_reg_write, 0);
    chk({name, "_mem_read"}, out_mem_read, 0);
    chk({name, "_mem_write"}, out_mem_write, 0);
    chk({name, "_result"}, out_result, 0);
    chk({name, "_store_data"}, out_store_data, 0);
    chk({name, "_redirect_pc"}, redirect_pc, 0);
    chk({name, "_epc"}, epc, 0);
    chk({name, "_dest"}, out_dest, 0);
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r,
                      input logic [31:0] s, input logic [2:0] f);
    instruction = i; pc = p; alu_result = r; store_data = s; alu_flags = f;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  logic [31:0] burst_i [8];
  logic [31:0] burst_p [8];
  logic [2:0]  burst_f [8];

  initial begin
    burst_i = '{32'h20090000, 32'h20000000, 32'h340A00FF, 32'h8C070010,
                32'hAC050000, 32'h1400FFFF, 32'h00622022, 32'hFC000000};
    burst_p = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h1000, 32'h28, 32'h2C};
    burst_f = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b100};

    rst_n = 0; in_valid = 0; instruction = 0; pc = 0; alu_result = 0; store_data = 0;
    alu_flags = 0; flush = 0; out_ready = 1;
    #12;
    chk_zero("reset");
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1;
    chk_en = 1;

    // add r3: result 5 one cycle later
    send(32'h00601820, 32'h0, 32'd5, 32'hAAAA, 3'b000);
    @(negedge clk);
    chk("add_out_valid", out_valid, 1);
    chk("add_out_dest", out_dest, 3);
    chk("add_reg_write", out_reg_write, 1);
    chk("add_result", out_result, 5);
    @(posedge clk); #1;

    // beq taken, then the pulse must drop
    send(32'h10000001, 32'h100, 32'd0, 32'd0, 3'b100);
    @(negedge clk);
    chk("beq_redirect", redirect_valid, 1);
    chk("beq_redirect_pc", redirect_pc, 32'h108);
    @(posedge clk); #1;
    @(negedge clk);
    chk("beq_pulse_once", redirect_valid, 0);
    @(posedge clk); #1;

    // beq not taken
    send(32'h10000001, 32'h100, 32'd1, 32'd0, 3'b000);
    @(negedge clk);
    chk("beq_nt_redirect", redirect_valid, 0);
    chk("beq_nt_reg_write", out_reg_write, 0);
    @(posedge clk); #1;

    // bne taken with target wrapping past 2^32
    send(32'h14000001, 32'hFFFF_FFF8, 32'd0, 32'd0, 3'b000);
    @(negedge clk);
    chk("bne_wrap_redirect", redirect_valid, 1);
    chk("bne_wrap_pc", redirect_pc, 32'h0);
    @(posedge clk); #1;

    // back-to-back burst, model-checked
    for (int k = 0; k < 8; k++) begin
      send(burst_i[k], burst_p[k], 32'h100 + k, 32'h200 + k, burst_f[k]);
    end
    @(posedge clk); #1;

    // stall: held entry, no repeated pulse, then drain+capture on one edge
    out_ready = 0;
    send(32'h10000002, 32'h200, 32'h11, 32'h0, 3'b100);
    instruction = 32'h8C070010; pc = 32'h204; alu_result = 32'h22; alu_flags = 0;
    in_valid = 1;
    @(negedge clk);
    chk("stall_first_pulse", redirect_valid, 1);
    chk("stall_redirect_pc", redirect_pc, 32'h20C);
    chk("stall_in_ready0", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_no_repulse", redirect_valid, 0);
      chk("stall_result_held", out_result, 32'h11);
      chk("stall_out_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    chk("swap_result", out_result, 32'h22);
    chk("swap_mem_read", out_mem_read, 1);
    chk("swap_dest", out_dest, 7);
    @(posedge clk); #1;

    // sw with rt field 5
    send(32'hAC050000, 32'h300, 32'h400, 32'hDEAD_BEEF, 3'b000);
    @(negedge clk);
    chk("sw_reg_write", out_reg_write, 0);
    chk("sw_mem_write", out_mem_write, 1);
    chk("sw_store_data", out_store_data, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    // add with overflow flag
    send(32'h00601820, 32'h40, 32'h8000_0000, 32'h0, 3'b001);
    @(negedge clk);
`ifdef EX_MEM_OVF_TRAP_EN
    chk("ovf_exc_valid", exc_valid, 1);
    chk("ovf_epc", epc, 32'h40);
    chk("ovf_redirect", redirect_valid, 1);
    chk("ovf_redirect_pc", redirect_pc, 32'h80);
    chk("ovf_reg_write", out_reg_write, 0);
`else
    chk("ovf_exc_valid", exc_valid, 0);
    chk("ovf_redirect", redirect_valid, 0);
    chk("ovf_reg_write", out_reg_write, 1);
`endif
    @(posedge clk); #1;

    // flush while FULL with a taken branch arriving
    out_ready = 0;
    send(32'h8C070010, 32'h500, 32'h33, 32'h0, 3'b000);
    flush = 1;
    instruction = 32'h10000001; pc = 32'h600; alu_flags = 3'b100; in_valid = 1;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_redirect", redirect_valid, 0);
    @(posedge clk); #1;
    out_ready = 1;

    // reset in the middle of a stall
    out_ready = 0;
    send(32'h10000001, 32'h700, 32'h55, 32'h66, 3'b100);
    @(negedge clk);
    chk("pre_rst_redirect", redirect_valid, 1);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk_zero("rst_mid");
    @(posedge clk); #1;
    rst_n = 1;
    out_ready = 1;
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_redirect", redirect_valid, 0);
    @(posedge clk); #1;

    send(32'h00601820, 32'h800, 32'd9, 32'd0, 3'b000);
    @(negedge clk);
    chk("alive_result", out_result, 9);
    @(posedge clk); #1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
